// File: rtl/rice_inverse_preprocessor.sv
// Rice decoder back end: undoes the CCSDS unit-delay prediction and mapping,
// emitting one reconstructed sample per symbol over a valid/ready stream.
module rice_inverse_preprocessor #(
    parameter int NSYM  = 10,
    parameter int SYMW  = 32,
    parameter int SAMPW = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NSYM*SYMW-1:0] symbol,
    input  logic                 blk_valid,
    input  logic                 refblk,
    input  logic [5:0]           j,
    input  logic [5:0]           n,
    output logic                 blk_ready,
    output logic [SAMPW-1:0]     sample,
    output logic                 samp_valid,
    input  logic                 samp_ready,
    output logic                 blkdone,
    output logic                 err
);

    localparam int IDXW = $clog2(NSYM + 1);

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        DONE
    } state_t;

    state_t           state_q;
    logic [SYMW-1:0]  symBuf_q [NSYM];
    logic [5:0]       jBlk_q;
    logic [5:0]       nBlk_q;
    logic [IDXW-1:0]  idx_q;
    logic [SAMPW-1:0] sample_q;
    logic [SAMPW-1:0] xhat_q;
    logic             sampValid_q;
    logic             blkReady_q;
    logic             blkDone_q;
    logic             err_q;
    logic             haveRef_q;
    logic             pendUpd_q;
    logic             pendRef_q;

    logic             acceptBlk;
    logic             acceptSamp;
    logic             lastSamp;
    logic             badJ;
    logic [IDXW-1:0]  nxtIdx;

    assign acceptBlk  = (state_q == IDLE) && blk_valid && blkReady_q;
    assign acceptSamp = (state_q == EMIT) && sampValid_q && samp_ready;
    assign lastSamp   = (6'(idx_q) == (jBlk_q - 6'd1));
    assign badJ       = (j == 6'd0) || (j > 6'(NSYM));
    assign nxtIdx     = idx_q + 1'b1;

    // The first symbol is decoded straight off the input bus so it can be
    // registered in the acceptance cycle; later symbols come from the buffer
    // and see the predictor as it will be once the current sample is taken.
    logic [SYMW-1:0]  curSym;
    logic             curRef;
    logic [5:0]       curN;
    logic [SAMPW-1:0] curXhat;
    logic             curHave;

    always_comb begin
        curSym  = '0;
        curRef  = 1'b0;
        curN    = nBlk_q;
        curXhat = pendUpd_q ? sample_q : xhat_q;
        curHave = haveRef_q | pendRef_q;
        if (state_q == IDLE) begin
            curSym  = symbol[SYMW-1:0];
            curRef  = refblk;
            curN    = n;
            curXhat = xhat_q;
            curHave = haveRef_q;
        end else if (nxtIdx < IDXW'(NSYM)) begin
            curSym = symBuf_q[nxtIdx];
        end
    end

    logic [4:0]             nEff;
    logic                   nBad;
    logic [SAMPW:0]         xmaxW;
    logic [SAMPW-1:0]       xmax;
    logic [SAMPW-1:0]       predRaw;
    logic [SAMPW-1:0]       pred;
    logic [SAMPW-1:0]       room;
    logic [SAMPW-1:0]       theta;
    logic [SAMPW:0]         twoTheta;
    logic [SAMPW:0]         delta;
    logic [SAMPW:0]         halfUp;
    logic signed [SAMPW+1:0] resid;
    logic signed [SAMPW+1:0] sum;
    logic [SAMPW-1:0]       sample_d;
    logic                   upd_d;
    logic                   ref_d;
    logic                   symErr_d;

    always_comb begin
        nBad     = (curN < 6'd2) || (curN > 6'(SAMPW));
        nEff     = (curN > 6'(SAMPW)) ? 5'(SAMPW) : curN[4:0];
        xmaxW    = ((SAMPW+1)'(1) << nEff) - (SAMPW+1)'(1);
        xmax     = xmaxW[SAMPW-1:0];
        predRaw  = curHave ? curXhat : '0;
        pred     = (predRaw > xmax) ? xmax : predRaw;
        room     = xmax - pred;
        theta    = (pred < room) ? pred : room;
        twoTheta = {theta, 1'b0};
        delta    = curSym[SAMPW:0];
        halfUp   = (delta + 1'b1) >> 1;
        resid    = '0;
        sum      = '0;
        sample_d = pred;
        upd_d    = 1'b0;
        ref_d    = 1'b0;
        symErr_d = 1'b0;
        if (curRef) begin
            sample_d = curSym[SAMPW-1:0] & xmax;
            upd_d    = 1'b1;
            ref_d    = 1'b1;
            symErr_d = (curSym & ~SYMW'(xmax)) != '0;
        end else if (curSym > SYMW'(xmax)) begin
            symErr_d = 1'b1;
        end else begin
            if (delta <= twoTheta) begin
                if (!delta[0]) begin
                    resid = $signed({2'b00, delta[SAMPW:1]});
                end else begin
                    resid = -$signed({1'b0, halfUp});
                end
            end else if (pred <= room) begin
                resid = $signed({1'b0, delta}) - $signed({2'b00, theta});
            end else begin
                resid = $signed({2'b00, theta}) - $signed({1'b0, delta});
            end
            sum      = $signed({2'b00, pred}) + resid;
            sample_d = sum[SAMPW-1:0];
            upd_d    = 1'b1;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{xmaxW[SAMPW], sum[SAMPW+1:SAMPW]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            symBuf_q    <= '{default: '0};
            jBlk_q      <= '0;
            nBlk_q      <= '0;
            idx_q       <= '0;
            sample_q    <= '0;
            xhat_q      <= '0;
            sampValid_q <= 1'b0;
            blkReady_q  <= 1'b1;
            blkDone_q   <= 1'b0;
            err_q       <= 1'b0;
            haveRef_q   <= 1'b0;
            pendUpd_q   <= 1'b0;
            pendRef_q   <= 1'b0;
        end else begin
            blkDone_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (acceptBlk) begin
                        for (int i = 0; i < NSYM; i++) begin
                            symBuf_q[i] <= symbol[i*SYMW +: SYMW];
                        end
                        jBlk_q     <= j;
                        nBlk_q     <= n;
                        idx_q      <= '0;
                        blkReady_q <= 1'b0;
                        if (badJ) begin
                            err_q     <= 1'b1;
                            blkDone_q <= 1'b1;
                            state_q   <= DONE;
                        end else begin
                            sample_q    <= sample_d;
                            sampValid_q <= 1'b1;
                            pendUpd_q   <= upd_d;
                            pendRef_q   <= ref_d;
                            if (symErr_d || nBad) begin
                                err_q <= 1'b1;
                            end
                            state_q <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    if (acceptSamp) begin
                        if (pendUpd_q) begin
                            xhat_q <= sample_q;
                        end
                        haveRef_q <= haveRef_q | pendRef_q;
                        if (lastSamp) begin
                            sampValid_q <= 1'b0;
                            pendUpd_q   <= 1'b0;
                            pendRef_q   <= 1'b0;
                            blkDone_q   <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            idx_q     <= nxtIdx;
                            sample_q  <= sample_d;
                            pendUpd_q <= upd_d;
                            pendRef_q <= ref_d;
                            if (symErr_d || nBad) begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    blkReady_q <= 1'b1;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign blk_ready  = blkReady_q;
    assign sample     = sample_q;
    assign samp_valid = sampValid_q;
    assign blkdone    = blkDone_q;
    assign err        = err_q;

endmodule

// File: tb/tb_rice_inverse_preprocessor.sv
// Directed, table-driven bench for rice_inverse_preprocessor with hand-computed samples.
module tb_rice_inverse_preprocessor;

   localparam int NSYM  = 10;
   localparam int SYMW  = 32;
   localparam int SAMPW = 16;
   localparam int NVEC  = 7;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NSYM*SYMW-1:0] symbol;
   logic                 blkValid;
   logic                 refBlk;
   logic [5:0]           jIn;
   logic [5:0]           nIn;
   logic                 blkReady;
   logic [SAMPW-1:0]     sampleOut;
   logic                 sampValid;
   logic                 sampReady;
   logic                 blkDone;
   logic                 errOut;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      logic refb;
      int   n;
      int   j;
      int   syms[NSYM];
      int   exps[NSYM];
   } vec_t;

   vec_t vecs[NVEC];
   vec_t bpVec;
   vec_t errVecA;
   vec_t errVecB;
   vec_t badJVec;
   vec_t rstVec;
   vec_t postVec;

   rice_inverse_preprocessor #(
      .NSYM (NSYM),
      .SYMW (SYMW),
      .SAMPW(SAMPW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .symbol    (symbol),
      .blk_valid (blkValid),
      .refblk    (refBlk),
      .j         (jIn),
      .n         (nIn),
      .blk_ready (blkReady),
      .sample    (sampleOut),
      .samp_valid(sampValid),
      .samp_ready(sampReady),
      .blkdone   (blkDone),
      .err       (errOut)
   );

   // Free-running 10 ns clock
   always #5 clk = ~clk;

   // Absolute guard so the run can never hang even if a bounded loop is miscoded
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // One comparison: count it, and report any difference on a single line
   task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Wait (bounded) for blk_ready, then present one block for exactly one accepting edge.
   // Returns #1 after the acceptance edge, i.e. in the first sample cycle.
   task automatic applyStimulus(input vec_t v);
      int waitCycles;
      waitCycles = 0;
      while (!blkReady && waitCycles < 50) begin
         @(posedge clk);
         #1;
         waitCycles++;
      end
      checkVal("blk_ready_before_block", 32'(blkReady), 32'd1);
      for (int i = 0; i < NSYM; i++) begin
         symbol[i*SYMW +: SYMW] = v.syms[i];
      end
      jIn      = 6'(v.j);
      nIn      = 6'(v.n);
      refBlk   = v.refb;
      blkValid = 1'b1;
      @(posedge clk);
      #1;
      blkValid = 1'b0;
   endtask

   // Collect cnt samples with samp_ready held high, compare each against the
   // table, then check the blkdone pulse and the return to blk_ready.
   task automatic checkOutput(input string tag, input vec_t v, input int cnt, input bit fullRate);
      int got;
      int cycles;
      got    = 0;
      cycles = 0;
      if (cnt > 0) begin
         checkVal({tag, "_latency_valid"}, 32'(sampValid), 32'd1);
         checkVal({tag, "_blk_ready_low"}, 32'(blkReady), 32'd0);
      end
      while (got < cnt && cycles < 200) begin
         if (sampValid && sampReady) begin
            checkVal($sformatf("%s_sample%0d", tag, got), 32'(sampleOut), v.exps[got]);
            got++;
         end
         @(posedge clk);
         #1;
         cycles++;
      end
      checkVal({tag, "_sample_count"}, got, cnt);
      if (fullRate) begin
         checkVal({tag, "_stream_cycles"}, cycles, cnt);
      end
      checkVal({tag, "_blkdone_high"}, 32'(blkDone), 32'd1);
      checkVal({tag, "_valid_low_in_done"}, 32'(sampValid), 32'd0);
      @(posedge clk);
      #1;
      checkVal({tag, "_blkdone_low"}, 32'(blkDone), 32'd0);
      checkVal({tag, "_blk_ready_high"}, 32'(blkReady), 32'd1);
   endtask

   // Main sequence: reset checks, table vectors, then the multi-cycle corner cases
   initial begin
      int got;
      int cyc;
      logic prevStall;
      logic [SAMPW-1:0] prevSample;

      reset     = 1'b1;
      blkValid  = 1'b0;
      refBlk    = 1'b0;
      jIn       = '0;
      nIn       = '0;
      symbol    = '0;
      sampReady = 1'b1;

      vecs[0] = '{refb: 1'b1, n: 8,  j: 4, syms: '{100, 4, 3, 0, 0, 0, 0, 0, 0, 0},    exps: '{100, 102, 100, 100, 0, 0, 0, 0, 0, 0}};
      vecs[1] = '{refb: 1'b1, n: 8,  j: 2, syms: '{250, 20, 0, 0, 0, 0, 0, 0, 0, 0},   exps: '{250, 235, 0, 0, 0, 0, 0, 0, 0, 0}};
      vecs[2] = '{refb: 1'b0, n: 8,  j: 1, syms: '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0},      exps: '{235, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
      vecs[3] = '{refb: 1'b1, n: 8,  j: 2, syms: '{3, 10, 0, 0, 0, 0, 0, 0, 0, 0},     exps: '{3, 10, 0, 0, 0, 0, 0, 0, 0, 0}};
      vecs[4] = '{refb: 1'b0, n: 8,  j: 1, syms: '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0},      exps: '{9, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
      vecs[5] = '{refb: 1'b1, n: 16, j: 3, syms: '{1000, 2000, 1, 0, 0, 0, 0, 0, 0, 0}, exps: '{1000, 2000, 1999, 0, 0, 0, 0, 0, 0, 0}};
      vecs[6] = '{refb: 1'b1, n: 2,  j: 3, syms: '{2, 3, 0, 0, 0, 0, 0, 0, 0, 0},      exps: '{2, 0, 0, 0, 0, 0, 0, 0, 0, 0}};

      bpVec   = '{refb: 1'b1, n: 16, j: 10, syms: '{500, 0, 2, 1, 4, 3, 6, 5, 8, 7},
                  exps: '{500, 500, 501, 500, 502, 500, 503, 500, 504, 500}};
      errVecA = '{refb: 1'b1, n: 4, j: 2, syms: '{5, 16, 0, 0, 0, 0, 0, 0, 0, 0}, exps: '{5, 5, 0, 0, 0, 0, 0, 0, 0, 0}};
      errVecB = '{refb: 1'b0, n: 4, j: 1, syms: '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0},  exps: '{5, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
      badJVec = '{refb: 1'b1, n: 8, j: 0, syms: '{7, 0, 0, 0, 0, 0, 0, 0, 0, 0},  exps: '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
      rstVec  = '{refb: 1'b1, n: 8, j: 10, syms: '{50, 0, 0, 0, 0, 0, 0, 0, 0, 0}, exps: '{50, 50, 50, 50, 50, 50, 50, 50, 50, 50}};
      postVec = '{refb: 1'b1, n: 8, j: 2, syms: '{77, 2, 0, 0, 0, 0, 0, 0, 0, 0},  exps: '{77, 78, 0, 0, 0, 0, 0, 0, 0, 0}};

      // Outputs while reset is held
      repeat (2) @(posedge clk);
      #1;
      checkVal("reset_blk_ready", 32'(blkReady), 32'd1);
      checkVal("reset_samp_valid", 32'(sampValid), 32'd0);
      checkVal("reset_sample", 32'(sampleOut), 32'd0);
      checkVal("reset_blkdone", 32'(blkDone), 32'd0);
      checkVal("reset_err", 32'(errOut), 32'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Table vectors at full rate; predictor state carries from one to the next
      for (int k = 0; k < NVEC; k++) begin
         applyStimulus(vecs[k]);
         checkOutput($sformatf("vec%0d", k), vecs[k], vecs[k].j, 1'b1);
      end
      checkVal("err_after_clean_blocks", 32'(errOut), 32'd0);

      // Backpressure: ready follows 1,0,0 repeating; stalled outputs must hold
      got        = 0;
      cyc        = 0;
      prevStall  = 1'b0;
      prevSample = '0;
      applyStimulus(bpVec);
      while (got < 10 && cyc < 200) begin
         sampReady = (cyc % 3 == 0);
         if (prevStall) begin
            checkVal($sformatf("bp_hold_sample_c%0d", cyc), 32'(sampleOut), 32'(prevSample));
            checkVal($sformatf("bp_hold_valid_c%0d", cyc), 32'(sampValid), 32'd1);
         end
         checkVal($sformatf("bp_blk_ready_c%0d", cyc), 32'(blkReady), 32'd0);
         if (sampValid && sampReady) begin
            checkVal($sformatf("bp_sample%0d", got), 32'(sampleOut), bpVec.exps[got]);
            got++;
            prevStall = 1'b0;
         end else begin
            prevStall  = sampValid;
            prevSample = sampleOut;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      sampReady = 1'b1;
      checkVal("bp_sample_count", got, 32'd10);
      checkVal("bp_blkdone_high", 32'(blkDone), 32'd1);
      checkVal("bp_blk_ready_in_done", 32'(blkReady), 32'd0);
      @(posedge clk);
      #1;
      checkVal("bp_blkdone_low", 32'(blkDone), 32'd0);
      checkVal("bp_blk_ready_high", 32'(blkReady), 32'd1);

      // Out-of-range delta holds the predictor; bad j produces only blkdone
      applyStimulus(errVecA);
      checkOutput("errA", errVecA, 2, 1'b1);
      checkVal("err_after_range", 32'(errOut), 32'd1);
      applyStimulus(errVecB);
      checkOutput("errB", errVecB, 1, 1'b1);
      applyStimulus(badJVec);
      checkOutput("badJ", badJVec, 0, 1'b1);
      checkVal("err_after_bad_j", 32'(errOut), 32'd1);

      // Asynchronous reset while the third of ten samples is on the bus
      applyStimulus(rstVec);
      checkVal("rst_sample0", 32'(sampleOut), 32'd50);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      checkVal("rst_sample2_valid", 32'(sampValid), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      checkVal("rst_async_valid", 32'(sampValid), 32'd0);
      checkVal("rst_async_blk_ready", 32'(blkReady), 32'd1);
      checkVal("rst_async_err", 32'(errOut), 32'd0);
      checkVal("rst_async_sample", 32'(sampleOut), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      applyStimulus(postVec);
      checkOutput("post_reset", postVec, 2, 1'b1);
      checkVal("post_reset_err", 32'(errOut), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
